linebuffer_scanout: RTL and testbench
=====================================

// Module: linebuffer_scanout
// PURPOSE
//  Display-side reader of the double-buffered scanline RAM pair. Each line it reads
//  the display bank pixel by pixel, expands RGB565 to 24-bit VGA colour and writes
//  BG_COLOR back behind each read so the bank is clean for the next draw.
//  At line end it swaps banks when the draw engine reports done, then requests the next line.
// PARAMETERS
//  H_ACTIVE   640      visible pixels per line (one pixel = 2 clk)
//  LINE_CLKS  1600     clk cycles per line (hcount range 0..LINE_CLKS-1)
//  V_ACTIVE   480      visible lines
//  V_TOTAL    525      total lines per frame (vcount range 0..V_TOTAL-1)
//  BG_COLOR   16'h0000 RGB565 value written back after each pixel read
// PORTS
//  clk              in   1   system clock (2x pixel clock)
//  reset            in   1   synchronous, active-low reset
//  hcount           in   11  horizontal position in clk units, from VGA counters
//  vcount           in   10  current line number
//  addr_pixel_disp  out  10  pixel address into display bank
//  data_pixel_disp  out  16  write data into display bank (always BG_COLOR)
//  wren_pixel_disp  out  1   write enable into display bank
//  q_pixel_disp     in   16  display-bank read data, valid 2 clk after address
//  switch           out  1   bank select: 1 = RAM0 display / RAM1 draw
//  draw_done        in   1   level: draw engine has finished its line
//  line_req         out  1   1-clk pulse: draw engine starts line draw_line
//  draw_line        out  10  line number to draw, valid while line_req=1
//  underrun         out  1   1-clk pulse: swap skipped because draw_done=0
//  vga_r/vga_g/vga_b out 8 each  pixel colour, registered
// BEHAVIOUR
//  Reset (reset=0 at clk edge): switch=0, addr=0, data=BG_COLOR, wren=0, line_req=0,
//   draw_line=0, underrun=0, vga_r/g/b=0; FSM -> INIT0.
//  Read/clear cycle, every line, all states, for hcount < 2*H_ACTIVE, x = hcount>>1:
//   hcount even: addr=x, wren=0 (read). hcount odd: addr=x, wren=1, data=BG_COLOR.
//   hcount >= 2*H_ACTIVE: addr=0, wren=0. Outputs driven combinationally from hcount.
//  Colour: pixel x is registered onto vga_* at hcount 2x+3 and held through 2x+4
//   (3-clk latency); downstream delays blank/sync by 3 clk.
//   r={p[15:11],p[15:13]}, g={p[10:5],p[10:9]}, b={p[4:0],p[4:2]}.
//   vga_*=0 when the pipelined pixel is outside x<H_ACTIVE or its line >= V_ACTIVE.
//  Line end E = (hcount==LINE_CLKS-1); v = vcount at E.
//  FSM:
//   INIT0: at E with v==V_TOTAL-3: toggle switch -> INIT1 (no draw_done check).
//   INIT1: at E: toggle switch, line_req next clk with draw_line=0 -> RUN.
//    (Both banks get fully cleared as display bank before first draw.)
//   RUN: at E: if draw_done=1 -> toggle switch; next clk line_req=1 and
//    draw_line=(v+2) mod V_TOTAL.
//    If draw_done=0 -> switch unchanged, no line_req, underrun=1 for 1 clk.
//    The just-cleared bank is then shown again: line displays BG_COLOR; draw continues.
//  switch changes only at E, so no bank change happens mid-read.
//  draw_done sampled only at E; draw engine drops it on line_req.
//  Reset mid-line: all outputs return to reset values next clk; any line_req
//   in flight is lost; the draw engine must also be reset.
//  Wrap: draw_line wraps V_TOTAL-2 -> 0 and V_TOTAL-1 -> 1.
// TESTING
//  1 Reset, run to first RUN line: switch toggles at ends of lines 522 and 523;
//    line_req pulses with draw_line=0 one clk after hcount=1599 of line 523.
//  2 Bank preloaded with p[5]=16'hF800: vga_r=8'hFF, vga_g=0, vga_b=0 at hcount 13,14;
//    write BG_COLOR to addr 5 at hcount 11.
//  3 draw_done=1 at end of line 100: switch toggles, line_req with draw_line=102.
//  4 draw_done=0 at end of line 100: no toggle, underrun 1 clk, no line_req;
//    line 101 shows all-zero RGB.
//  5 Line 523 in RUN: draw_line=0; line 524: draw_line=1.
//    vcount=480: all vga_* stay 0 while clear writes still occur.
//  6 Assert reset at hcount=700: wren=0, vga_*=0, switch=0 next clk; FSM back in INIT0.

Source files
------------

// File: rtl/linebuffer_scanout.sv
// rtl/linebuffer_scanout.sv - display-side scanline bank reader with clear-behind and bank swap
module linebuffer_scanout #(
  parameter int          H_ACTIVE  = 640,
  parameter int          LINE_CLKS = 1600,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_TOTAL   = 525,
  parameter logic [15:0] BG_COLOR  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [9:0]  addr_pixel_disp,
  output logic [15:0] data_pixel_disp,
  output logic        wren_pixel_disp,
  input  logic [15:0] q_pixel_disp,
  output logic        switch,
  input  logic        draw_done,
  output logic        line_req,
  output logic [9:0]  draw_line,
  output logic        underrun,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  typedef enum logic [1:0] {S_INIT0, S_INIT1, S_RUN} state_t;

  state_t      state_q, state_d;
  logic        switch_q, switch_d;
  logic        line_req_q, line_req_d;
  logic [9:0]  draw_line_q, draw_line_d;
  logic        underrun_q, underrun_d;
  logic [23:0] rgb_q, rgb_d;

  logic        line_end;
  logic        pix_ok;
  logic [10:0] next_line;

  assign line_end = (hcount == 11'(LINE_CLKS - 1));

  // Even clk reads pixel x, odd clk writes background behind it; held idle in reset.
  always_comb begin
    addr_pixel_disp = '0;
    wren_pixel_disp = 1'b0;
    data_pixel_disp = BG_COLOR;
    if (reset && (hcount < 11'(2 * H_ACTIVE))) begin
      addr_pixel_disp = hcount[10:1];
      wren_pixel_disp = hcount[0];
    end
  end

  // q holds pixel (hcount>>1)-1 on even clks; odd clks may see read-during-write data, so hold.
  assign pix_ok = (hcount >= 11'd2) && (hcount <= 11'(2 * H_ACTIVE)) &&
                  (vcount < 10'(V_ACTIVE));

  always_comb begin
    rgb_d = rgb_q;
    if (!hcount[0]) begin
      if (pix_ok) begin
        rgb_d = {q_pixel_disp[15:11], q_pixel_disp[15:13],
                 q_pixel_disp[10:5],  q_pixel_disp[10:9],
                 q_pixel_disp[4:0],   q_pixel_disp[4:2]};
      end else begin
        rgb_d = '0;
      end
    end
  end

  always_comb begin
    next_line = {1'b0, vcount} + 11'd2;
    if (next_line >= 11'(V_TOTAL)) begin
      next_line = next_line - 11'(V_TOTAL);
    end
  end

  always_comb begin
    state_d     = state_q;
    switch_d    = switch_q;
    line_req_d  = 1'b0;
    draw_line_d = draw_line_q;
    underrun_d  = 1'b0;
    if (line_end) begin
      case (state_q)
        S_INIT0: begin
          if (vcount == 10'(V_TOTAL - 3)) begin
            switch_d = ~switch_q;
            state_d  = S_INIT1;
          end
        end
        S_INIT1: begin
          switch_d    = ~switch_q;
          line_req_d  = 1'b1;
          draw_line_d = '0;
          state_d     = S_RUN;
        end
        S_RUN: begin
          if (draw_done) begin
            switch_d    = ~switch_q;
            line_req_d  = 1'b1;
            draw_line_d = next_line[9:0];
          end else begin
            underrun_d = 1'b1;
          end
        end
        default: state_d = S_INIT0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_INIT0;
      switch_q    <= 1'b0;
      line_req_q  <= 1'b0;
      draw_line_q <= '0;
      underrun_q  <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      switch_q    <= switch_d;
      line_req_q  <= line_req_d;
      draw_line_q <= draw_line_d;
      underrun_q  <= underrun_d;
      rgb_q       <= rgb_d;
    end
  end

  assign switch    = switch_q;
  assign line_req  = line_req_q;
  assign draw_line = draw_line_q;
  assign underrun  = underrun_q;
  assign vga_r     = rgb_q[23:16];
  assign vga_g     = rgb_q[15:8];
  assign vga_b     = rgb_q[7:0];

endmodule

// File: tb/tb_linebuffer_scanout.sv
// tb/tb_linebuffer_scanout.sv - self-checking bench for linebuffer_scanout with bank RAM model
module tb_linebuffer_scanout;
  localparam int H_ACTIVE  = 640;
  localparam int LINE_CLKS = 1600;
  localparam int V_ACTIVE  = 480;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [9:0]  addr_pixel_disp;
  logic [15:0] data_pixel_disp;
  logic        wren_pixel_disp;
  logic [15:0] q_pixel_disp;
  logic        switch;
  logic        draw_done;
  logic        line_req;
  logic [9:0]  draw_line;
  logic        underrun;
  logic [7:0]  vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  linebuffer_scanout dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .addr_pixel_disp(addr_pixel_disp), .data_pixel_disp(data_pixel_disp),
    .wren_pixel_disp(wren_pixel_disp), .q_pixel_disp(q_pixel_disp),
    .switch(switch), .draw_done(draw_done), .line_req(line_req),
    .draw_line(draw_line), .underrun(underrun),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // Two RAM banks, 2-clk read latency; switch=1 shows RAM0.
  bit   [15:0] ram [2][1024];
  logic [15:0] rd1;
  logic        disp_bank;
  logic        pl_en;
  logic        pl_bank;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  assign disp_bank = ~switch;

  always @(posedge clk) begin
    rd1          <= ram[disp_bank][addr_pixel_disp];
    q_pixel_disp <= rd1;
    if (wren_pixel_disp) ram[disp_bank][addr_pixel_disp] <= data_pixel_disp;
    if (pl_en) ram[pl_bank][pl_addr] <= pl_data;
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_mem [2][640];
  bit          exp_sw;
  logic [23:0] sb[$];
  logic [23:0] held;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  addr;
    logic        wren;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [23:0] expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic preload(input bit bank, input int n, input int f_addr, input logic [15:0] f_data);
    hcount = 11'd1500;
    for (int i = 0; i < n; i++) begin
      pl_bank = bank;
      if (i == 0 && f_addr >= 0) begin
        pl_addr = 10'(f_addr);
        pl_data = f_data;
      end else begin
        pl_addr = 10'($urandom_range(0, H_ACTIVE - 1));
        pl_data = 16'($urandom);
        if (f_addr >= 0 && pl_addr == 10'(f_addr)) pl_data = f_data;
      end
      exp_mem[bank][pl_addr] = pl_data;
      pl_en = 1'b1;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_line(input logic [9:0] v, input bit dd, input bit tog, input bit exp_req,
                          input logic [9:0] exp_dl, input bit exp_under, input bit chk_p5);
    int reqs = 0;
    int unders = 0;
    int nz = 0;
    bit bank = ~exp_sw;
    vcount = v;
    draw_done = dd;
    for (int h = 0; h < LINE_CLKS; h++) begin
      hcount = 11'(h);
      #1;
      if (h >= 1) begin
        reqs += int'(line_req);
        unders += int'(underrun);
      end
      if (h % 2 == 0 && h < 2 * H_ACTIVE)
        sb.push_back((v < V_ACTIVE) ? expand(exp_mem[bank][h / 2]) : 24'h0);
      if (h % 2 == 1 && h >= 3 && h <= 2 * H_ACTIVE + 1) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          held = sb.pop_front();
          chk("vga", {vga_r, vga_g, vga_b}, held);
        end
      end
      if (h % 2 == 0 && h >= 4 && h <= 2 * H_ACTIVE + 2)
        chk("vga_hold", {vga_r, vga_g, vga_b}, held);
      if (chk_p5 && h == 11) begin
        chk("p5_addr", addr_pixel_disp, 5);
        chk("p5_wren", wren_pixel_disp, 1);
        chk("p5_data", data_pixel_disp, 0);
      end
      if (chk_p5 && (h == 13 || h == 14))
        chk("p5_rgb", {vga_r, vga_g, vga_b}, 24'hFF0000);
      @(posedge clk); #1;
    end
    hcount = 11'd0;
    if (tog) exp_sw = ~exp_sw;
    chk("switch", switch, exp_sw);
    chk("line_req", line_req, exp_req);
    if (exp_req) chk("draw_line", draw_line, exp_dl);
    chk("underrun", underrun, exp_under);
    chk("req_inline", reqs, 0);
    chk("under_inline", unders, 0);
    chk("sb_left", sb.size(), 0);
    for (int i = 0; i < H_ACTIVE; i++) begin
      if (ram[bank][i] != 16'h0) nz++;
      exp_mem[bank][i] = 16'h0;
    end
    chk("bank_cleared", nz, 0);
  endtask

  initial begin
    reset = 1'b0; hcount = '0; vcount = '0; draw_done = 1'b0;
    pl_en = 1'b0; pl_bank = 1'b0; pl_addr = '0; pl_data = '0;
    exp_sw = 1'b0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < H_ACTIVE; i++) exp_mem[b][i] = 16'h0;
    vecs[0] = '{11'd0,    10'd0,   1'b0};
    vecs[1] = '{11'd1,    10'd0,   1'b1};
    vecs[2] = '{11'd10,   10'd5,   1'b0};
    vecs[3] = '{11'd11,   10'd5,   1'b1};
    vecs[4] = '{11'd1278, 10'd639, 1'b0};
    vecs[5] = '{11'd1279, 10'd639, 1'b1};
    vecs[6] = '{11'd1280, 10'd0,   1'b0};
    vecs[7] = '{11'd1599, 10'd0,   1'b0};

    repeat (3) @(posedge clk);
    #1 hcount = 11'd1;
    #1;
    chk("rst_switch", switch, 0);
    chk("rst_addr", addr_pixel_disp, 0);
    chk("rst_wren", wren_pixel_disp, 0);
    chk("rst_data", data_pixel_disp, 0);
    chk("rst_line_req", line_req, 0);
    chk("rst_draw_line", draw_line, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);

    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hcount = vecs[i].h;
      #1;
      chk("vec_addr", addr_pixel_disp, vecs[i].addr);
      chk("vec_wren", wren_pixel_disp, vecs[i].wren);
      chk("vec_data", data_pixel_disp, 0);
    end
    @(posedge clk); #1;

    // Initialisation: two clear-only lines, then first request for line 0.
    run_line(10'd522, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    run_line(10'd523, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0);

    // Normal swap with a known red pixel at x=5.
    preload(~exp_sw, 12, 5, 16'hF800);
    run_line(10'd100, 1'b1, 1'b1, 1'b1, 10'd102, 1'b0, 1'b1);

    // Underrun: same bank shown again, now cleared.
    preload(~exp_sw, 12, -1, 16'h0);
    run_line(10'd101, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
    run_line(10'd102, 1'b1, 1'b1, 1'b1, 10'd104, 1'b0, 1'b0);

    // Blanked line still clears; wrap of draw_line.
    preload(~exp_sw, 12, -1, 16'h0);
    run_line(10'd480, 1'b1, 1'b1, 1'b1, 10'd482, 1'b0, 1'b0);
    run_line(10'd523, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0);
    run_line(10'd524, 1'b1, 1'b1, 1'b1, 10'd1, 1'b0, 1'b0);

    // Mid-line reset with switch=1 and a visible pixel on screen.
    preload(~exp_sw, 1, 348, 16'hFFFF);
    vcount = 10'd10;
    draw_done = 1'b1;
    for (int h = 0; h < 700; h++) begin
      hcount = 11'(h);
      @(posedge clk); #1;
    end
    hcount = 11'd700;
    #1;
    chk("pre_rst_rgb", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    chk("pre_rst_switch", switch, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    hcount = 11'd701;
    #1;
    chk("mid_rst_wren", wren_pixel_disp, 0);
    chk("mid_rst_addr", addr_pixel_disp, 0);
    chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("mid_rst_switch", switch, 0);
    chk("mid_rst_line_req", line_req, 0);
    reset = 1'b1;
    exp_sw = 1'b0;
    sb.delete();
    for (int h = 702; h < 1400; h++) begin
      hcount = 11'(h);
      @(posedge clk); #1;
    end
    // Back in INIT0: line ends away from 522 are ignored even with draw_done.
    run_line(10'd100, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    run_line(10'd522, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
